univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register built on synchronous-reset flops: hold, load,
//  logical/arithmetic shifts and rotates. Adds a burst engine that performs N shifts
//  automatically with busy/done status. Serves as serialiser/deserialiser and general
//  data-path storage in the lab designs.
// PARAMETERS
//  WIDTH    8      register width in bits (>=2)
//  RST_VAL  0      value loaded into q on reset (WIDTH bits)
//  CW       $clog2(WIDTH+1)  burst-count width (localparam, derived)
// PORTS
//  clk     in   1      single clock; all state updates on posedge clk
//  r       in   1      reset, synchronous and active-high
//  en      in   1      operation enable; 0 = hold all state (manual op and burst stall)
//  mode    in   3      operation select (encodings in BEHAVIOUR)
//  d       in   WIDTH  parallel load data
//  sin_l   in   1      serial in at LSB side, used by SHL
//  sin_r   in   1      serial in at MSB side, used by SHR
//  start   in   1      launch burst of nshift ops of type mode
//  nshift  in   CW     burst length, sampled with start
//  q       out  WIDTH  register contents
//  sout_l  out  1      q[WIDTH-1], combinational from q
//  sout_r  out  1      q[0], combinational from q
//  busy    out  1      burst in progress
//  done    out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset (r=1 at posedge, overrides everything incl. mid-burst): q<=RST_VAL, busy<=0,
//   done<=0, count<=0, latched mode<=HOLD.
//  Modes: 000 HOLD; 001 LOAD q<=d; 010 SHL q<={q[W-2:0],sin_l}; 011 SHR q<={sin_r,q[W-1:1]};
//   100 ROL q<={q[W-2:0],q[W-1]}; 101 ROR q<={q[0],q[W-1:1]};
//   110 ASR q<={q[W-1],q[W-1:1]}; 111 CLR q<=0 (not RST_VAL).
//  FSM IDLE/BUSY. done defaults to 0 every cycle.
//  IDLE, en=1, start=0: apply mode once, latency 1 cycle.
//  IDLE, en=1, start=1, mode in {SHL,SHR,ROL,ROR,ASR}:
//   nshift=0 -> no shift, done=1 next cycle, stay IDLE.
//   nshift>0 -> latch mode, apply first op this edge, count<=nshift-1;
//   if nshift=1 -> done next cycle, stay IDLE; else busy<=1, go BUSY.
//  IDLE, start=1 with HOLD/LOAD/CLR: treated as single manual op, no done, no busy.
//  BUSY, en=1: apply latched mode, count--; op where count was 1 is last ->
//   busy<=0, done<=1 (same edge), go IDLE. Total burst = nshift enabled cycles.
//  BUSY, en=0: full stall; q, count, busy unchanged.
//  BUSY: mode, d, start, nshift ignored; serial inputs sampled live each shift.
//  nshift>WIDTH legal: all shifts performed (rotates wrap, shifts flush).
//  en=0 in IDLE: start ignored, q held.
// STRUCTURE
//  Package shreg_pkg: mode localparams (MODE_HOLD..MODE_CLR), FSM state encodings.
//  Sub-module shreg_next_val: combinational (mode,q,d,sin_l,sin_r) -> next q;
//   top holds FSM, counter, q register.
// TESTING (WIDTH=8, RST_VAL=8'h00 unless noted)
//  1 q=8'hA5, r=1 one edge -> q=8'h00, busy=0, done=0; RST_VAL=8'h3C run -> q=8'h3C, CLR -> 8'h00.
//  2 LOAD 8'h81; SHL sin_l=1 -> q=8'h03; SHR sin_r=0 -> 8'h01; ASR on 8'h90 -> 8'hC8.
//  3 q=8'h01, start ROR nshift=3 -> q 8'h80,8'h40,8'h20 on 3 edges; busy high 2 cycles; done pulse once.
//  4 Same burst with en=0 for 2 cycles mid-burst -> q/busy frozen, done 2 cycles later, final 8'h20.
//  5 start nshift=0 -> q unchanged, done 1 cycle; nshift=9 ROL on 8'h01 -> q=8'h02.
//  6 r=1 during burst (count=2) -> q=8'h00, busy=0, no done; start/mode changes while BUSY ignored.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// burst FSM states and a helper that classifies which modes may be bursted.
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Only the shift/rotate family can be repeated by the burst engine.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shreg_next_val.sv
// Combinational next-value selector: maps an operation and the current
// register contents (plus serial inputs) to the value loaded on the next edge.
module shreg_next_val
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_next = '0;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a burst engine that repeats a shift/rotate
// operation nshift times, reporting busy while running and a done pulse at the end.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CW-1:0]    nshift,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [2:0]       mode_lat, mode_lat_n;
    logic [2:0]       op_mode;
    logic [WIDTH-1:0] q_n, shifted;
    logic             done_n;

    // While bursting the latched op runs; live mode/d/start are ignored.
    assign op_mode = (state == ST_BUSY) ? mode_lat : mode;

    shreg_next_val #(.WIDTH(WIDTH)) u_next_val (
        .mode   (op_mode),
        .q      (q),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (shifted)
    );

    always_ff @(posedge clk) begin
        if (r) begin
            state    <= ST_IDLE;
            q        <= RST_VAL;
            count    <= '0;
            mode_lat <= MODE_HOLD;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            count    <= count_n;
            mode_lat <= mode_lat_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        q_n        = q;
        count_n    = count;
        mode_lat_n = mode_lat;
        done_n     = 1'b0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start && is_burst_mode(mode)) begin
                        if (nshift == '0) begin
                            done_n = 1'b1;
                        end else begin
                            // First op of the burst happens on the launching edge.
                            q_n        = shifted;
                            mode_lat_n = mode;
                            count_n    = nshift - CW'(1);
                            if (nshift == CW'(1)) done_n  = 1'b1;
                            else                  state_n = ST_BUSY;
                        end
                    end else begin
                        q_n = shifted;
                    end
                end
                ST_BUSY: begin
                    q_n     = shifted;
                    count_n = count - CW'(1);
                    if (count == CW'(1)) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign busy   = (state == ST_BUSY);
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed table, burst corner cases,
// and randomized traffic against a behavioural model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          r, en, sin_l, sin_r, start;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic [CW-1:0] nshift;
    logic [W-1:0]  q, q2;
    logic          sout_l, sout_r, busy, done;
    logic          sout_l2, sout_r2, busy2, done2;

    int tests  = 0;
    int failed = 0;
    bit chk_model = 0;

    // behavioural model state
    logic [W-1:0] m_q;
    bit           m_busy, m_done;
    int           m_rem;
    logic [2:0]   m_mode;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .clk(clk), .r(r), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .start(start), .nshift(nshift), .q(q), .sout_l(sout_l), .sout_r(sout_r),
        .busy(busy), .done(done)
    );

    univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h3C)) dut2 (
        .clk(clk), .r(r), .en(en), .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .start(start), .nshift(nshift), .q(q2), .sout_l(sout_l2), .sout_r(sout_r2),
        .busy(busy2), .done(done2)
    );

    function automatic logic [W-1:0] apply(input logic [2:0] m, input logic [W-1:0] v);
        int x;
        x = int'(v);
        case (m)
            3'd1: x = int'(d);
            3'd2: x = ((x * 2) + int'(sin_l)) % 256;
            3'd3: x = (x / 2) + (sin_r ? 128 : 0);
            3'd4: x = ((x * 2) % 256) + (x / 128);
            3'd5: x = (x / 2) + ((x % 2) * 128);
            3'd6: x = (x / 2) + ((x >= 128) ? 128 : 0);
            3'd7: x = 0;
            default: ;
        endcase
        return x[W-1:0];
    endfunction

    task automatic model_step();
        if (r) begin
            m_q = 8'h00; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 3'd0;
            return;
        end
        m_done = 0;
        if (!en) return;
        if (m_busy) begin
            m_q = apply(m_mode, m_q);
            m_rem--;
            if (m_rem == 0) begin m_busy = 0; m_done = 1; end
        end else if (start && mode >= 3'd2 && mode <= 3'd6) begin
            if (nshift == 0) m_done = 1;
            else begin
                m_q = apply(mode, m_q);
                m_mode = mode;
                m_rem = int'(nshift) - 1;
                if (m_rem == 0) m_done = 1; else m_busy = 1;
            end
        end else begin
            m_q = apply(mode, m_q);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_model) begin
            chk("rnd_q", 32'(q), 32'(m_q));
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_done", 32'(done), 32'(m_done));
            chk("rnd_sout_l", 32'(sout_l), 32'(m_q[W-1]));
            chk("rnd_sout_r", 32'(sout_r), 32'(m_q[0]));
        end
    endtask

    task automatic set_in(input logic [2:0] m, input logic [W-1:0] dv,
                          input logic st, input logic [CW-1:0] n);
        mode = m; d = dv; start = st; nshift = n;
    endtask

    typedef struct {
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         sl;
        logic         sr;
        logic [W-1:0] exp_q;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3'd1, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[1]  = '{3'd2, 8'h00, 1'b1, 1'b0, 8'h03};
        vecs[2]  = '{3'd3, 8'h00, 1'b0, 1'b0, 8'h01};
        vecs[3]  = '{3'd1, 8'h90, 1'b0, 1'b0, 8'h90};
        vecs[4]  = '{3'd6, 8'h00, 1'b0, 1'b0, 8'hC8};
        vecs[5]  = '{3'd4, 8'h00, 1'b0, 1'b0, 8'h91};
        vecs[6]  = '{3'd5, 8'h00, 1'b0, 1'b0, 8'hC8};
        vecs[7]  = '{3'd3, 8'h00, 1'b0, 1'b1, 8'hE4};
        vecs[8]  = '{3'd7, 8'h55, 1'b1, 1'b1, 8'h00};
        vecs[9]  = '{3'd0, 8'hFF, 1'b1, 1'b1, 8'h00};
        vecs[10] = '{3'd1, 8'h7F, 1'b0, 1'b0, 8'h7F};
        vecs[11] = '{3'd6, 8'h00, 1'b0, 1'b0, 8'h3F};

        r = 1; en = 0; sin_l = 0; sin_r = 0;
        set_in(3'd0, 8'h00, 1'b0, '0);
        cyc();

        // reset values, including non-zero RST_VAL instance
        r = 0; en = 1; set_in(3'd1, 8'hA5, 1'b0, '0);
        cyc();
        chk("load_a5", 32'(q), 32'h A5);
        r = 1; cyc();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_q_3c", 32'(q2), 32'h3C);
        r = 0; set_in(3'd7, 8'h00, 1'b0, '0); cyc();
        chk("clr_3c", 32'(q2), 32'h00);

        // single-op table
        foreach (vecs[i]) begin
            set_in(vecs[i].mode, vecs[i].d, 1'b0, '0);
            sin_l = vecs[i].sl; sin_r = vecs[i].sr;
            cyc();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
        end
        sin_l = 0; sin_r = 0;

        // ROR burst of 3 from 8'h01
        set_in(3'd1, 8'h01, 1'b0, '0); cyc();
        set_in(3'd5, 8'h00, 1'b1, CW'(3)); cyc();
        chk("b3_q0", 32'(q), 32'h80); chk("b3_busy0", 32'(busy), 1); chk("b3_done0", 32'(done), 0);
        set_in(3'd0, 8'h00, 1'b0, '0); cyc();
        chk("b3_q1", 32'(q), 32'h40); chk("b3_busy1", 32'(busy), 1); chk("b3_done1", 32'(done), 0);
        cyc();
        chk("b3_q2", 32'(q), 32'h20); chk("b3_busy2", 32'(busy), 0); chk("b3_done2", 32'(done), 1);
        cyc();
        chk("b3_done_clr", 32'(done), 0); chk("b3_hold", 32'(q), 32'h20);

        // same burst with a 2-cycle stall
        set_in(3'd1, 8'h01, 1'b0, '0); cyc();
        set_in(3'd5, 8'h00, 1'b1, CW'(3)); cyc();
        set_in(3'd0, 8'h00, 1'b0, '0); en = 0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("stall_q", 32'(q), 32'h80); chk("stall_busy", 32'(busy), 1);
            chk("stall_done", 32'(done), 0);
        end
        en = 1; cyc();
        chk("stall_q1", 32'(q), 32'h40); chk("stall_done1", 32'(done), 0);
        cyc();
        chk("stall_q2", 32'(q), 32'h20); chk("stall_done2", 32'(done), 1);
        chk("stall_busy2", 32'(busy), 0);

        // nshift=0 and nshift>WIDTH
        set_in(3'd1, 8'h5A, 1'b0, '0); cyc();
        set_in(3'd2, 8'h00, 1'b1, '0); cyc();
        chk("n0_q", 32'(q), 32'h5A); chk("n0_done", 32'(done), 1); chk("n0_busy", 32'(busy), 0);
        set_in(3'd1, 8'h01, 1'b0, '0); cyc();
        chk("n0_done_clr", 32'(done), 0);
        set_in(3'd4, 8'h00, 1'b1, CW'(9)); cyc();
        set_in(3'd0, 8'h00, 1'b0, '0);
        for (int k = 0; k < 7; k++) cyc();
        chk("n9_busy8", 32'(busy), 1); chk("n9_done8", 32'(done), 0);
        cyc();
        chk("n9_q", 32'(q), 32'h02); chk("n9_done", 32'(done), 1); chk("n9_busy", 32'(busy), 0);

        // changes while BUSY ignored, then reset mid-burst
        set_in(3'd1, 8'h01, 1'b0, '0); cyc();
        set_in(3'd5, 8'h00, 1'b1, CW'(4)); cyc();
        set_in(3'd1, 8'hFF, 1'b1, CW'(1)); cyc();
        chk("ign_q", 32'(q), 32'h40); chk("ign_busy", 32'(busy), 1); chk("ign_done", 32'(done), 0);
        r = 1; set_in(3'd0, 8'h00, 1'b0, '0); cyc();
        chk("mid_rst_q", 32'(q), 32'h00); chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        r = 0; en = 0; cyc();
        chk("post_rst_done", 32'(done), 0); chk("post_rst_q", 32'(q), 32'h00);

        // randomized traffic against the model
        chk_model = 1;
        for (int k = 0; k < 400; k++) begin
            r      = ($urandom_range(0, 39) == 0);
            en     = ($urandom_range(0, 3) != 0);
            mode   = 3'($urandom_range(0, 7));
            d      = 8'($urandom);
            sin_l  = 1'($urandom);
            sin_r  = 1'($urandom);
            start  = ($urandom_range(0, 4) == 0);
            nshift = CW'($urandom_range(0, 11));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
